// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch feeding a circular fetch queue.
// Define FETCH_PERF_EN to add the perf_fetched / perf_full_stall / perf_squashed counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        fq_full,
  output logic        fq_write_en,
  output logic [63:0] fq_write_data
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_full_stall,
  output logic [31:0] perf_squashed
`endif
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] req_pc_q;
  logic [31:0] hold_data_q;
  logic        squash_q;
  logic        handshake;
  logic        capture;

  assign imem_req_addr = pc_q;
  assign handshake     = imem_req_valid && imem_req_ready;
  // A live response that meets a full queue is parked in hold_data_q.
  assign capture       = (state_q == S_WAIT) && imem_resp_valid && !squash_q &&
                         !redirect_valid && fq_full;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_REQ;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ:  if (handshake) state_d = S_WAIT;
      S_WAIT: if (imem_resp_valid) state_d = capture ? S_HOLD : S_REQ;
      S_HOLD: if (redirect_valid || !fq_full) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    imem_req_valid = 1'b0;
    fq_write_en    = 1'b0;
    fq_write_data  = (state_q == S_HOLD) ? {req_pc_q, hold_data_q}
                                         : {req_pc_q, imem_resp_data};
    // Redirect suppresses both the request and any push in the same cycle.
    if (!reset && !redirect_valid) begin
      case (state_q)
        S_REQ:  imem_req_valid = 1'b1;
        S_WAIT: fq_write_en    = imem_resp_valid && !squash_q && !fq_full;
        S_HOLD: fq_write_en    = !fq_full;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      req_pc_q    <= 32'h0;
      hold_data_q <= 32'h0;
      squash_q    <= 1'b0;
    end else begin
      if (redirect_valid) pc_q <= redirect_pc & 32'hFFFF_FFFC;
      else if (handshake) pc_q <= pc_q + 32'd4;
      if (handshake) req_pc_q <= pc_q;
      // squash marks the outstanding response as stale; the response itself clears it.
      if (state_q == S_WAIT) begin
        if (imem_resp_valid)     squash_q <= 1'b0;
        else if (redirect_valid) squash_q <= 1'b1;
      end
      if (capture) hold_data_q <= imem_resp_data;
    end
  end

`ifdef FETCH_PERF_EN
  logic drop_resp;
  assign drop_resp = ((state_q == S_WAIT) && imem_resp_valid && (squash_q || redirect_valid)) ||
                     ((state_q == S_HOLD) && redirect_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched    <= 32'h0;
      perf_full_stall <= 32'h0;
      perf_squashed   <= 32'h0;
    end else begin
      if (fq_write_en)        perf_fetched    <= perf_fetched + 32'd1;
      if (state_q == S_HOLD)  perf_full_stall <= perf_full_stall + 32'd1;
      if (drop_resp)          perf_squashed   <= perf_squashed + 32'd1;
    end
  end
`endif

  resp_only_in_wait: assert property (@(posedge clk) disable iff (reset)
    imem_resp_valid |-> (state_q == S_WAIT))
    else $error("imem_resp_valid asserted outside WAIT");

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run against a flag-based reference model.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        fq_full = 1'b0;
  logic        fq_write_en;
  logic [63:0] fq_write_data;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_full_stall, perf_squashed;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fq_full(fq_full), .fq_write_en(fq_write_en), .fq_write_data(fq_write_data)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_full_stall(perf_full_stall),
    .perf_squashed(perf_squashed)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Instruction memory: one request at a time, response pulse mem_lat cycles after handshake.
  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic        mem_busy = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  always @(posedge clk) begin
    imem_resp_valid <= 1'b0;
    if (reset) begin
      mem_busy <= 1'b0;
    end else if (imem_req_valid && imem_req_ready) begin
      if (mem_lat <= 1) begin
        imem_resp_valid <= 1'b1;
        imem_resp_data  <= instr_of(imem_req_addr);
      end else begin
        mem_busy <= 1'b1;
        mem_cnt  <= mem_lat - 1;
        mem_addr <= imem_req_addr;
      end
    end else if (mem_busy) begin
      mem_cnt <= mem_cnt - 1;
      if (mem_cnt == 1) begin
        mem_busy        <= 1'b0;
        imem_resp_valid <= 1'b1;
        imem_resp_data  <= instr_of(mem_addr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bring the DUT to REQ with nothing outstanding (bounded wait).
  task automatic go_idle();
    bit ok;
    ok = 1'b0;
    imem_req_ready = 1'b0; fq_full = 1'b0; redirect_valid = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      @(negedge clk);
      if (imem_req_valid) ok = 1'b1;
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL idle_timeout: req_valid never rose within 20 cycles"); end
  endtask

  task automatic jump(input logic [31:0] a);
    tick(); redirect_valid = 1'b1; redirect_pc = a;
    tick(); redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_req_ready = 1'b1; fq_full = 1'b0; redirect_valid = 1'b0; mem_lat = 1;
    repeat (3) begin
      tick();
      @(negedge clk);
      n_checks++;
      if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
      n_checks++;
      if (fq_write_en !== 1'b0) begin n_fail++; $display("FAIL reset_write_en: got %b want 0", fq_write_en); end
      n_checks++;
      if (imem_req_addr !== RST_PC) begin n_fail++; $display("FAIL reset_pc: got %h want %h", imem_req_addr, RST_PC); end
    end
  endtask

  task automatic test_stream();
    logic [31:0] p;
    tick(); reset = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c % 2 == 1) begin
        p = RST_PC + 32'(4 * ((c - 1) / 2));
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== p) begin
          n_fail++; $display("FAIL stream_req c%0d: got v=%b a=%h want v=1 a=%h", c, imem_req_valid, imem_req_addr, p);
        end
        n_checks++;
        if (fq_write_en !== 1'b0) begin n_fail++; $display("FAIL stream_nopush c%0d: got %b want 0", c, fq_write_en); end
      end else begin
        p = RST_PC + 32'(4 * (c / 2 - 1));
        n_checks++;
        if (fq_write_en !== 1'b1 || fq_write_data !== {p, instr_of(p)}) begin
          n_fail++; $display("FAIL stream_push c%0d: got en=%b d=%h want en=1 d=%h", c, fq_write_en, fq_write_data, {p, instr_of(p)});
        end
      end
      tick();
    end
  endtask

  task automatic test_full_hold();
`ifdef FETCH_PERF_EN
    logic [31:0] s_stall, s_fetch;
`endif
    go_idle(); jump(32'h0); mem_lat = 1; imem_req_ready = 1'b1;
    @(negedge clk);
`ifdef FETCH_PERF_EN
    s_stall = perf_full_stall; s_fetch = perf_fetched;
`endif
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      n_fail++; $display("FAIL hold_req: got v=%b a=%h want v=1 a=0", imem_req_valid, imem_req_addr);
    end
    tick(); imem_req_ready = 1'b0; fq_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (fq_write_en !== 1'b0 || imem_req_valid !== 1'b0) begin
        n_fail++; $display("FAIL hold_stall %0d: got en=%b req=%b want 0 0", i, fq_write_en, imem_req_valid);
      end
      tick();
    end
    fq_full = 1'b0;
    @(negedge clk);
    n_checks++;
    if (fq_write_en !== 1'b1 || fq_write_data !== {32'h0, instr_of(32'h0)}) begin
      n_fail++; $display("FAIL hold_release: got en=%b d=%h want en=1 d=%h", fq_write_en, fq_write_data, {32'h0, instr_of(32'h0)});
    end
    tick();
    @(negedge clk);
`ifdef FETCH_PERF_EN
    n_checks++;
    if (perf_full_stall - s_stall !== 32'd5) begin n_fail++; $display("FAIL perf_full_stall: got %0d want 5", perf_full_stall - s_stall); end
    n_checks++;
    if (perf_fetched - s_fetch !== 32'd1) begin n_fail++; $display("FAIL perf_fetched: got %0d want 1", perf_fetched - s_fetch); end
`endif
  endtask

  task automatic test_redirect_wait();
    bit seen_req, pushed, early;
    logic [63:0] pd;
`ifdef FETCH_PERF_EN
    logic [31:0] s_sq;
`endif
    seen_req = 0; pushed = 0; early = 0; pd = '0;
    go_idle(); jump(32'h40); mem_lat = 3; imem_req_ready = 1'b1;
    @(negedge clk);
`ifdef FETCH_PERF_EN
    s_sq = perf_squashed;
`endif
    n_checks++;
    if (imem_req_addr !== 32'h40 || imem_req_valid !== 1'b1) begin
      n_fail++; $display("FAIL rw_req: got v=%b a=%h want v=1 a=40", imem_req_valid, imem_req_addr);
    end
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h203;
    @(negedge clk);
    n_checks++;
    if (fq_write_en !== 1'b0) begin n_fail++; $display("FAIL rw_redirect_push: got %b want 0", fq_write_en); end
    tick(); redirect_valid = 1'b0;
    for (int i = 0; i < 20 && !pushed; i++) begin
      if (i > 0) tick();
      if (seen_req) imem_req_ready = 1'b0;
      @(negedge clk);
      if (imem_req_valid && !seen_req) begin
        seen_req = 1;
        n_checks++;
        if (imem_req_addr !== 32'h200) begin n_fail++; $display("FAIL rw_next_addr: got %h want 00000200", imem_req_addr); end
      end
      if (fq_write_en) begin pushed = 1; pd = fq_write_data; early = !seen_req; end
    end
    imem_req_ready = 1'b0;
    n_checks++;
    if (!pushed || early || pd !== {32'h200, instr_of(32'h200)}) begin
      n_fail++; $display("FAIL rw_push: got pushed=%b early=%b d=%h want pushed=1 early=0 d=%h", pushed, early, pd, {32'h200, instr_of(32'h200)});
    end
    tick();
    @(negedge clk);
`ifdef FETCH_PERF_EN
    n_checks++;
    if (perf_squashed - s_sq !== 32'd1) begin n_fail++; $display("FAIL perf_squashed_wait: got %0d want 1", perf_squashed - s_sq); end
`endif
  endtask

  task automatic test_redirect_resp();
`ifdef FETCH_PERF_EN
    logic [31:0] s_sq;
`endif
    go_idle(); jump(32'h60); mem_lat = 2; imem_req_ready = 1'b1;
    @(negedge clk);
`ifdef FETCH_PERF_EN
    s_sq = perf_squashed;
`endif
    n_checks++;
    if (imem_req_addr !== 32'h60) begin n_fail++; $display("FAIL rr_req: got %h want 00000060", imem_req_addr); end
    tick(); imem_req_ready = 1'b0;
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h80;
    @(negedge clk);
    n_checks++;
    if (fq_write_en !== 1'b0) begin n_fail++; $display("FAIL rr_same_cycle_push: got %b want 0", fq_write_en); end
    tick(); redirect_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80 || fq_write_en !== 1'b0) begin
      n_fail++; $display("FAIL rr_next_req: got v=%b a=%h en=%b want v=1 a=80 en=0", imem_req_valid, imem_req_addr, fq_write_en);
    end
`ifdef FETCH_PERF_EN
    n_checks++;
    if (perf_squashed - s_sq !== 32'd1) begin n_fail++; $display("FAIL perf_squashed_resp: got %0d want 1", perf_squashed - s_sq); end
`endif
  endtask

  task automatic test_redirect_hold();
    go_idle(); jump(32'h300); mem_lat = 1; imem_req_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (imem_req_addr !== 32'h300) begin n_fail++; $display("FAIL rh_req: got %h want 00000300", imem_req_addr); end
    tick(); imem_req_ready = 1'b0; fq_full = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (fq_write_en !== 1'b0) begin n_fail++; $display("FAIL rh_full %0d: got %b want 0", i, fq_write_en); end
      tick();
    end
    redirect_valid = 1'b1; redirect_pc = 32'h400;
    @(negedge clk);
    n_checks++;
    if (fq_write_en !== 1'b0) begin n_fail++; $display("FAIL rh_redirect_push: got %b want 0", fq_write_en); end
    tick(); redirect_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h400) begin
      n_fail++; $display("FAIL rh_next_req: got v=%b a=%h want v=1 a=400", imem_req_valid, imem_req_addr);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) fq_full = 1'b0;
      @(negedge clk);
      n_checks++;
      if (fq_write_en !== 1'b0) begin n_fail++; $display("FAIL rh_discarded %0d: got %b want 0", i, fq_write_en); end
    end
  endtask

  task automatic test_wrap();
    go_idle(); jump(32'hFFFF_FFFC); mem_lat = 1; imem_req_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL wrap_req: got v=%b a=%h want v=1 a=fffffffc", imem_req_valid, imem_req_addr);
    end
    tick(); imem_req_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (fq_write_en !== 1'b1 || fq_write_data !== {32'hFFFF_FFFC, instr_of(32'hFFFF_FFFC)}) begin
      n_fail++; $display("FAIL wrap_push: got en=%b d=%h", fq_write_en, fq_write_data);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      n_fail++; $display("FAIL wrap_next: got v=%b a=%h want v=1 a=0", imem_req_valid, imem_req_addr);
    end
  endtask

  // Reference: fetch slot is either free or owns one request (alive or killed, word in hand or not).
  task automatic test_random();
    logic [31:0] m_pc, m_reqpc;
    bit m_busy, m_alive, m_word, exp_req, exp_push;
    int pushes;
`ifdef FETCH_PERF_EN
    logic [31:0] s_fetch;
`endif
    go_idle(); jump(32'h1000);
    m_pc = 32'h1000; m_reqpc = 32'h0; m_busy = 0; m_alive = 0; m_word = 0; pushes = 0;
`ifdef FETCH_PERF_EN
    s_fetch = perf_fetched;
`endif
    for (int c = 0; c < 10000; c++) begin
      redirect_valid = ($urandom % 16) == 0;
      redirect_pc    = $urandom;
      fq_full        = ($urandom % 3) == 0;
      imem_req_ready = $urandom % 2;
      mem_lat        = 1 + int'($urandom % 4);
      @(negedge clk);
      n_checks++;
      if (fq_write_en && fq_full) begin n_fail++; $display("FAIL rnd_write_full c%0d: en=%b full=%b", c, fq_write_en, fq_full); end
      exp_req = !m_busy && !redirect_valid;
      n_checks++;
      if (imem_req_valid !== exp_req) begin n_fail++; $display("FAIL rnd_req_valid c%0d: got %b want %b", c, imem_req_valid, exp_req); end
      if (exp_req) begin
        n_checks++;
        if (imem_req_addr !== m_pc) begin n_fail++; $display("FAIL rnd_req_addr c%0d: got %h want %h", c, imem_req_addr, m_pc); end
      end
      exp_push = m_busy && m_alive && !redirect_valid && !fq_full && (imem_resp_valid || m_word);
      n_checks++;
      if (fq_write_en !== exp_push) begin n_fail++; $display("FAIL rnd_push c%0d: got %b want %b", c, fq_write_en, exp_push); end
      if (exp_push) begin
        pushes++;
        n_checks++;
        if (fq_write_data !== {m_reqpc, instr_of(m_reqpc)}) begin
          n_fail++; $display("FAIL rnd_push_data c%0d: got %h want %h", c, fq_write_data, {m_reqpc, instr_of(m_reqpc)});
        end
      end
      if (redirect_valid) begin
        m_pc = redirect_pc & 32'hFFFF_FFFC;
        if (m_busy) begin
          if (m_word || imem_resp_valid) m_busy = 0;
          else m_alive = 0;
        end
      end else if (!m_busy) begin
        if (imem_req_ready) begin
          m_busy = 1; m_alive = 1; m_word = 0; m_reqpc = m_pc; m_pc = m_pc + 32'd4;
        end
      end else if (imem_resp_valid && !m_word) begin
        if (!m_alive || !fq_full) m_busy = 0;
        else m_word = 1;
      end else if (m_word && !fq_full) begin
        m_busy = 0;
      end
      tick();
    end
    redirect_valid = 1'b0; fq_full = 1'b0; imem_req_ready = 1'b0;
    @(negedge clk);
`ifdef FETCH_PERF_EN
    n_checks++;
    if (perf_fetched - s_fetch !== 32'(pushes)) begin
      n_fail++; $display("FAIL rnd_perf_fetched: got %0d want %0d", perf_fetched - s_fetch, pushes);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full_hold();
    test_redirect_wait();
    test_redirect_resp();
    test_redirect_hold();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
